// File: rtl/mem_dma_master_if.sv
// Control and RAM-bus bundle for mem_dma_master.
// The master modport is the DMA engine's view; slave is the host/RAM side.
interface mem_dma_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 16
) ();
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] fill_value;
  logic              abort;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  xfer_count;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  start, mode, src, dst, len, fill_value, abort, mem_rdata,
    output busy, done, xfer_count, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output start, mode, src, dst, len, fill_value, abort, mem_rdata,
    input  busy, done, xfer_count, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_dma_master.sv
// DMA bus initiator for a single-port word RAM: COPY (read src, write dst) or FILL (constant).
// Optional MEM_DMA_CHECKSUM_EN adds a running sum of all written words on port checksum.
module mem_dma_master #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
`ifdef MEM_DMA_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  mem_dma_master_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [LEN_W-1:0]  xfer_count_q, xfer_count_d;
  // Holds the word read in READ for COPY, or the captured fill constant for FILL.
  logic [DATA_W-1:0] data_q, data_d;
`ifdef MEM_DMA_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;
`else
  // No checksum state in this build.
`endif

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    src_ptr_d    = src_ptr_q;
    dst_ptr_d    = dst_ptr_q;
    remaining_d  = remaining_q;
    xfer_count_d = xfer_count_q;
    data_d       = data_q;
`ifdef MEM_DMA_CHECKSUM_EN
    checksum_d   = checksum_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          mode_d       = bus.mode;
          src_ptr_d    = bus.src;
          dst_ptr_d    = bus.dst;
          remaining_d  = bus.len;
          xfer_count_d = '0;
          data_d       = bus.mode ? bus.fill_value : '0;
`ifdef MEM_DMA_CHECKSUM_EN
          checksum_d   = '0;
`endif
          if (bus.len == '0) begin
            state_d = StDone;
          end else begin
            state_d = bus.mode ? StWrite : StRead;
          end
        end
      end
      StRead: begin
        data_d  = bus.mem_rdata;
        state_d = bus.abort ? StIdle : StWrite;
      end
      StWrite: begin
        // The write in this cycle always lands, so bookkeeping advances even on abort.
        xfer_count_d = xfer_count_q + LEN_W'(1);
        src_ptr_d    = src_ptr_q + ADDR_W'(1);
        dst_ptr_d    = dst_ptr_q + ADDR_W'(1);
        remaining_d  = remaining_q - LEN_W'(1);
`ifdef MEM_DMA_CHECKSUM_EN
        checksum_d   = checksum_q + data_q;
`endif
        if (bus.abort) begin
          state_d = StIdle;
        end else if (remaining_q == LEN_W'(1)) begin
          state_d = StDone;
        end else begin
          state_d = mode_q ? StWrite : StRead;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      mode_q       <= 1'b0;
      src_ptr_q    <= '0;
      dst_ptr_q    <= '0;
      remaining_q  <= '0;
      xfer_count_q <= '0;
      data_q       <= '0;
`ifdef MEM_DMA_CHECKSUM_EN
      checksum_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      src_ptr_q    <= src_ptr_d;
      dst_ptr_q    <= dst_ptr_d;
      remaining_q  <= remaining_d;
      xfer_count_q <= xfer_count_d;
      data_q       <= data_d;
`ifdef MEM_DMA_CHECKSUM_EN
      checksum_q   <= checksum_d;
`endif
    end
  end

  // Outputs decode straight from registered state so an async reset clears them at once.
  always_comb begin
    bus.busy       = (state_q == StRead) || (state_q == StWrite);
    bus.done       = (state_q == StDone);
    bus.mem_we     = (state_q == StWrite);
    bus.xfer_count = xfer_count_q;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    unique case (state_q)
      StRead:  bus.mem_addr = src_ptr_q;
      StWrite: begin
        bus.mem_addr  = dst_ptr_q;
        bus.mem_wdata = data_q;
      end
      default: ;
    endcase
  end

`ifdef MEM_DMA_CHECKSUM_EN
  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_mem_dma_master.sv
// Scoreboard bench for mem_dma_master: a RAM model records DUT writes, each scenario
// pushes its expected writes when it starts a transfer and compares them afterwards.
module tb_mem_dma_master;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_dma_master_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) ifc ();
`ifdef MEM_DMA_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  mem_dma_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef MEM_DMA_CHECKSUM_EN
    .checksum (checksum),
`endif
    .bus      (ifc)
  );

  logic [DW-1:0] ram [256];
  assign ifc.mem_rdata = ram[ifc.mem_addr[7:0]];
  always @(posedge clk) if (ifc.mem_we === 1'b1) ram[ifc.mem_addr[7:0]] <= ifc.mem_wdata;

  wr_t obs_q[$];
  always @(negedge clk) if (ifc.mem_we === 1'b1) obs_q.push_back('{addr: ifc.mem_addr, data: ifc.mem_wdata});

  logic [DW-1:0] model [256];
  wr_t exp_q[$];
  int  checks = 0;
  int  fails = 0;
  int  rd_idx = 0;

  task automatic start_xfer(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [LW-1:0] n, input logic [DW-1:0] f, input int keep);
    logic [DW-1:0] v;
    @(negedge clk);
    ifc.start = 1'b1; ifc.mode = m; ifc.src = s; ifc.dst = d; ifc.len = n; ifc.fill_value = f;
    for (int i = 0; i < keep; i++) begin
      v = m ? f : model[8'(s + AW'(i))];
      model[8'(d + AW'(i))] = v;
      exp_q.push_back('{addr: d + AW'(i), data: v});
    end
    @(posedge clk);
    #1 ifc.start = 1'b0;
  endtask

  // Caller sits at the negedge of cycle `first`; returns the cycle done is seen, or -1.
  task automatic wait_done(input int first, output int cyc);
    cyc = first;
    while (ifc.done !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (ifc.done !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset();
    rst = 1'b0; ifc.start = 1'b0; ifc.mode = 1'b0; ifc.src = '0; ifc.dst = '0;
    ifc.len = '0; ifc.fill_value = '0; ifc.abort = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({ifc.busy, ifc.done, ifc.mem_we} !== 3'b000) begin
      fails++; $display("FAIL reset_ctrl: got %b required 000", {ifc.busy, ifc.done, ifc.mem_we});
    end
    checks++;
    if (ifc.mem_addr !== '0 || ifc.mem_wdata !== '0) begin
      fails++; $display("FAIL reset_bus: got %0h/%0h required 0/0", ifc.mem_addr, ifc.mem_wdata);
    end
    checks++;
    if (ifc.xfer_count !== '0) begin
      fails++; $display("FAIL reset_count: got %0d required 0", ifc.xfer_count);
    end
`ifdef MEM_DMA_CHECKSUM_EN
    checks++;
    if (checksum !== '0) begin fails++; $display("FAIL reset_csum: got %0h required 0", checksum); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_fill();
    int  c;
    wr_t e;
    start_xfer(1'b1, '0, 32'h10, 16'd4, 32'hDEADBEEF, 4);
    @(negedge clk);
    wait_done(1, c);
    checks++; if (c != 5) begin fails++; $display("FAIL fill_done_cycle: got %0d required 5", c); end
    checks++;
    if (ifc.xfer_count !== 16'd4) begin
      fails++; $display("FAIL fill_count: got %0d required 4", ifc.xfer_count);
    end
    @(negedge clk);
    checks++;
    if (ifc.done !== 1'b0 || ifc.busy !== 1'b0) begin
      fails++; $display("FAIL fill_done_pulse: got done=%b busy=%b required 0 0", ifc.done, ifc.busy);
    end
    checks++;
    if (obs_q.size() - rd_idx != exp_q.size()) begin
      fails++; $display("FAIL fill_wr_count: got %0d required %0d", obs_q.size() - rd_idx, exp_q.size());
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd_idx >= obs_q.size()) begin fails++; $display("FAIL fill_wr: got none required %0h", e); end
      else if (obs_q[rd_idx] !== e) begin
        fails++; $display("FAIL fill_wr: got %0h required %0h", obs_q[rd_idx], e);
      end
      rd_idx++;
    end
    rd_idx = obs_q.size();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ram[8'h10 + 8'(i)] !== 32'hDEADBEEF) begin
        fails++; $display("FAIL fill_ram[%0d]: got %0h required deadbeef", i, ram[8'h10 + 8'(i)]);
      end
    end
  endtask

  task automatic test_copy();
    int  c;
    wr_t e;
    start_xfer(1'b0, 32'h10, 32'h20, 16'd3, '0, 3);
    @(negedge clk);
    checks++;
    if (ifc.mem_addr !== 32'h10 || ifc.mem_we !== 1'b0 || ifc.busy !== 1'b1) begin
      fails++; $display("FAIL copy_read: got addr=%0h we=%b busy=%b required 10 0 1",
                        ifc.mem_addr, ifc.mem_we, ifc.busy);
    end
    @(negedge clk);
    checks++;
    if (ifc.mem_addr !== 32'h20 || ifc.mem_we !== 1'b1 || ifc.mem_wdata !== 32'hDEADBEEF) begin
      fails++; $display("FAIL copy_write: got addr=%0h we=%b data=%0h required 20 1 deadbeef",
                        ifc.mem_addr, ifc.mem_we, ifc.mem_wdata);
    end
    wait_done(2, c);
    checks++; if (c != 7) begin fails++; $display("FAIL copy_done_cycle: got %0d required 7", c); end
    checks++;
    if (ifc.xfer_count !== 16'd3) begin
      fails++; $display("FAIL copy_count: got %0d required 3", ifc.xfer_count);
    end
    checks++;
    if (obs_q.size() - rd_idx != exp_q.size()) begin
      fails++; $display("FAIL copy_wr_count: got %0d required %0d", obs_q.size() - rd_idx, exp_q.size());
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd_idx >= obs_q.size()) begin fails++; $display("FAIL copy_wr: got none required %0h", e); end
      else if (obs_q[rd_idx] !== e) begin
        fails++; $display("FAIL copy_wr: got %0h required %0h", obs_q[rd_idx], e);
      end
      rd_idx++;
    end
    rd_idx = obs_q.size();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ram[8'h20 + 8'(i)] !== 32'hDEADBEEF) begin
        fails++; $display("FAIL copy_ram[%0d]: got %0h required deadbeef", i, ram[8'h20 + 8'(i)]);
      end
    end
  endtask

  task automatic test_len_zero();
    int c;
    start_xfer(1'b0, 32'h10, 32'h70, 16'd0, '0, 0);
    @(negedge clk);
    wait_done(1, c);
    checks++; if (c != 1) begin fails++; $display("FAIL len0_done_cycle: got %0d required 1", c); end
    checks++;
    if (ifc.xfer_count !== '0 || ifc.busy !== 1'b0) begin
      fails++; $display("FAIL len0_state: got count=%0d busy=%b required 0 0", ifc.xfer_count, ifc.busy);
    end
    @(negedge clk); @(negedge clk);
    checks++;
    if (obs_q.size() != rd_idx) begin
      fails++; $display("FAIL len0_wr_count: got %0d required 0", obs_q.size() - rd_idx);
    end
    rd_idx = obs_q.size();
  endtask

  task automatic test_back_to_back();
    int  c1;
    int  c2;
    wr_t e;
    start_xfer(1'b1, '0, 32'h14, 16'd2, 32'h0BADF00D, 2);
    @(negedge clk);
    wait_done(1, c1);
    start_xfer(1'b1, '0, 32'h16, 16'd1, 32'h12345678, 1);
    @(negedge clk);
    wait_done(1, c2);
    checks++;
    if (c1 != 3 || c2 != 2) begin
      fails++; $display("FAIL b2b_done_cycle: got %0d,%0d required 3,2", c1, c2);
    end
    checks++;
    if (obs_q.size() - rd_idx != exp_q.size()) begin
      fails++; $display("FAIL b2b_wr_count: got %0d required %0d", obs_q.size() - rd_idx, exp_q.size());
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd_idx >= obs_q.size()) begin fails++; $display("FAIL b2b_wr: got none required %0h", e); end
      else if (obs_q[rd_idx] !== e) begin
        fails++; $display("FAIL b2b_wr: got %0h required %0h", obs_q[rd_idx], e);
      end
      rd_idx++;
    end
    rd_idx = obs_q.size();
  endtask

  task automatic test_start_ignored();
    int  c;
    int  extra;
    wr_t e;
    start_xfer(1'b0, 32'h12, 32'h30, 16'd5, '0, 5);
    @(negedge clk); @(negedge clk); @(negedge clk);
    ifc.start = 1'b1; ifc.mode = 1'b1; ifc.src = 32'h20; ifc.dst = 32'h31;
    ifc.len = 16'd2; ifc.fill_value = 32'h55;
    @(posedge clk);
    #1 ifc.start = 1'b0;
    @(negedge clk);
    wait_done(4, c);
    checks++; if (c != 11) begin fails++; $display("FAIL ign_done_cycle: got %0d required 11", c); end
    checks++;
    if (ifc.xfer_count !== 16'd5) begin
      fails++; $display("FAIL ign_count: got %0d required 5", ifc.xfer_count);
    end
    extra = 0;
    repeat (4) begin @(negedge clk); if (ifc.done === 1'b1) extra++; end
    checks++; if (extra != 0) begin fails++; $display("FAIL ign_extra_done: got %0d required 0", extra); end
    checks++;
    if (obs_q.size() - rd_idx != exp_q.size()) begin
      fails++; $display("FAIL ign_wr_count: got %0d required %0d", obs_q.size() - rd_idx, exp_q.size());
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd_idx >= obs_q.size()) begin fails++; $display("FAIL ign_wr: got none required %0h", e); end
      else if (obs_q[rd_idx] !== e) begin
        fails++; $display("FAIL ign_wr: got %0h required %0h", obs_q[rd_idx], e);
      end
      rd_idx++;
    end
    rd_idx = obs_q.size();
  endtask

  task automatic test_abort();
    int  seen;
    wr_t e;
    start_xfer(1'b1, '0, 32'h40, 16'd8, 32'hCAFE0000, 2);
    @(negedge clk); @(negedge clk);
    ifc.abort = 1'b1;
    @(posedge clk);
    #1 ifc.abort = 1'b0;
    checks++;
    if (ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.mem_we !== 1'b0) begin
      fails++; $display("FAIL abort_state: got busy=%b done=%b we=%b required 0 0 0",
                        ifc.busy, ifc.done, ifc.mem_we);
    end
    checks++;
    if (ifc.xfer_count !== 16'd2) begin
      fails++; $display("FAIL abort_count: got %0d required 2", ifc.xfer_count);
    end
`ifdef MEM_DMA_CHECKSUM_EN
    checks++;
    if (checksum !== 32'h95FC0000) begin
      fails++; $display("FAIL abort_csum: got %0h required 95fc0000", checksum);
    end
`endif
    seen = 0;
    repeat (4) begin @(negedge clk); if (ifc.done === 1'b1) seen++; end
    checks++; if (seen != 0) begin fails++; $display("FAIL abort_done: got %0d pulses required 0", seen); end
    checks++;
    if (obs_q.size() - rd_idx != exp_q.size()) begin
      fails++; $display("FAIL abort_wr_count: got %0d required %0d", obs_q.size() - rd_idx, exp_q.size());
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd_idx >= obs_q.size()) begin fails++; $display("FAIL abort_wr: got none required %0h", e); end
      else if (obs_q[rd_idx] !== e) begin
        fails++; $display("FAIL abort_wr: got %0h required %0h", obs_q[rd_idx], e);
      end
      rd_idx++;
    end
    rd_idx = obs_q.size();
  endtask

  task automatic test_reset_mid();
    wr_t e;
    start_xfer(1'b0, 32'h10, 32'h60, 16'd4, '0, 1);
    @(negedge clk); @(negedge clk); @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ifc.busy !== 1'b0 || ifc.mem_we !== 1'b0 || ifc.mem_addr !== '0 || ifc.xfer_count !== '0) begin
      fails++; $display("FAIL rst_mid: got busy=%b we=%b addr=%0h count=%0d required all 0",
                        ifc.busy, ifc.mem_we, ifc.mem_addr, ifc.xfer_count);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ifc.busy !== 1'b0) begin fails++; $display("FAIL rst_mid_idle: got busy=%b required 0", ifc.busy); end
    checks++;
    if (obs_q.size() - rd_idx != exp_q.size()) begin
      fails++; $display("FAIL rst_wr_count: got %0d required %0d", obs_q.size() - rd_idx, exp_q.size());
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd_idx >= obs_q.size()) begin fails++; $display("FAIL rst_wr: got none required %0h", e); end
      else if (obs_q[rd_idx] !== e) begin
        fails++; $display("FAIL rst_wr: got %0h required %0h", obs_q[rd_idx], e);
      end
      rd_idx++;
    end
    rd_idx = obs_q.size();
  endtask

`ifdef MEM_DMA_CHECKSUM_EN
  task automatic test_checksum();
    int c;
    start_xfer(1'b1, '0, 32'h90, 16'd2, 32'h1, 2);
    @(negedge clk);
    wait_done(1, c);
    checks++; if (c != 3) begin fails++; $display("FAIL csum_done_cycle: got %0d required 3", c); end
    checks++;
    if (checksum !== 32'd2) begin fails++; $display("FAIL csum_value: got %0h required 2", checksum); end
    exp_q.delete();
    rd_idx = obs_q.size();
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_copy();
    test_len_zero();
    test_back_to_back();
    test_start_ignored();
    test_abort();
    test_reset_mid();
`ifdef MEM_DMA_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
